lsu_align: RTL and testbench

Load/store alignment unit that sits directly upstream of the data memory, between the execute stage and the memory port. It accepts one load or store per request handshake, issues it to the data memory as one or more byte/half/word accesses, and returns load data, with byte lanes and sign/zero extension resolved. Misaligned halfword and word accesses are split into sequential byte accesses and reassembled little-endian.

---
 rtl/lsu_align.sv | 150 +++++++++++++++
 tb/tb_lsu_align.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit between the execute stage and the data memory port.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses into byte beats.
module lsu_align #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept, legal, misal, fault_in, last_beat;
  logic [DATA_WIDTH-1:0] load_res;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
  end

  assign misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic                  split_q;
  logic [1:0]            beat_q;
  logic [DATA_WIDTH-1:0] asm_q, asm_nx, ext;

  assign fault_in  = !legal;
  assign last_beat = !split_q || (beat_q == (f3_q[1] ? 2'd3 : 2'd1));

  // Current beat's byte folded in so the last beat is usable at the same edge.
  always_comb begin
    asm_nx = asm_q;
    asm_nx[8*beat_q +: 8] = mem_rd_data[7:0];
  end

  always_comb begin
    if (f3_q[1])      ext = asm_nx;
    else if (f3_q[2]) ext = {{(DATA_WIDTH-16){1'b0}}, asm_nx[15:0]};
    else              ext = {{(DATA_WIDTH-16){asm_nx[15]}}, asm_nx[15:0]};
  end

  assign load_res = split_q ? ext : mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      split_q <= 1'b0;
      beat_q  <= 2'd0;
      asm_q   <= '0;
    end else if (accept) begin
      split_q <= misal;
      beat_q  <= 2'd0;
      asm_q   <= '0;
    end else if (state == ACCESS) begin
      beat_q <= beat_q + 2'd1;
      asm_q  <= asm_nx;
    end
  end
`else
  assign fault_in  = !legal || misal;
  assign last_beat = 1'b1;
  assign load_res  = mem_rd_data;
`endif

  // Memory port is gated by reset so an aborting beat never writes.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_funct3  = 3'b000;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (state == ACCESS && !reset) begin
      mem_wr_en   = we_q;
      mem_funct3  = f3_q;
      mem_addr    = addr_q;
      mem_wr_data = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        mem_funct3  = we_q ? 3'b000 : 3'b100;
        mem_addr    = addr_q + ADDR_WIDTH'(beat_q);
        mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[8*beat_q +: 8]};
      end
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fault_in ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      f3_q       <= req_funct3;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      resp_rdata <= '0;
      resp_fault <= fault_in;
    end else if (state == ACCESS && last_beat) begin
      resp_rdata <= we_q ? '0 : load_res;
    end else if (state == RESP) begin
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// Randomized bench for lsu_align: byte-array memory plus a shadow-array reference model.
module tb_lsu_align;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_wr_en;
  logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic [2:0]  mem_funct3;

  lsu_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic [7:0] mem_arr [256];
  logic [7:0] shadow  [256];
  int n_tests = 0, n_fail = 0;
  logic [31:0] last_rd;
  logic        last_flt;

  always_comb begin : mem_rd
    logic [7:0]  a;
    logic [31:0] w;
    a = mem_addr[7:0];
    w = {mem_arr[a+8'd3], mem_arr[a+8'd2], mem_arr[a+8'd1], mem_arr[a]};
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{w[7]}}, w[7:0]};
      3'b001:  mem_rd_data = {{16{w[15]}}, w[15:0]};
      3'b100:  mem_rd_data = {24'h0, w[7:0]};
      3'b101:  mem_rd_data = {16'h0, w[15:0]};
      default: mem_rd_data = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem_arr[mem_addr[7:0]] = mem_wr_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem_arr[mem_addr[7:0]+8'd1] = mem_wr_data[15:8];
      if (mem_funct3[1]) begin
        mem_arr[mem_addr[7:0]+8'd2] = mem_wr_data[23:16];
        mem_arr[mem_addr[7:0]+8'd3] = mem_wr_data[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    mem_arr[a] = v;
    shadow[a]  = v;
  endtask

  // Architectural view: gather bytes little-endian, extend by funct3.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                output bit flt, output int nb, output bit [31:0] rd);
    int sz; bit ill, mis; bit [31:0] v; bit [7:0] ix;
    ill = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = 1 << f3[1:0];
    mis = !ill && ((addr & 32'(sz - 1)) != 0);
    flt = ill || (mis && !SPLIT);
    nb  = flt ? 0 : (mis ? sz : 1);
    v   = 0;
    if (!flt) begin
      for (int k = 0; k < sz; k++) begin
        ix = addr[7:0] + 8'(k);
        v  = v | (32'(shadow[ix]) << (8 * k));
      end
      if (sz == 1)      v = f3[2] ? (v & 32'hFF)   : {{24{v[7]}}, v[7:0]};
      else if (sz == 2) v = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
    end
    rd = (flt || we) ? 32'h0 : v;
  endfunction

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
    bit flt; int nb, n, k, wr_cnt; bit [31:0] rd, t; bit busy_rdy; bit [7:0] ix;
    model(we, f3, addr, flt, nb, rd);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    wr_cnt = 0; busy_rdy = 1'b0; k = 0;
    do begin
      @(negedge clk); k++;
      if (mem_wr_en) wr_cnt++;
      if (req_ready) busy_rdy = 1'b1;
      if (!resp_valid) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
      end
    end while (!resp_valid && k < 12);
    req_valid = 1'b0;
    last_rd = resp_rdata; last_flt = resp_fault;
    chk("latency", k, flt ? 1 : nb + 1);
    chk("fault", {31'h0, resp_fault}, {31'h0, flt});
    chk("rdata", resp_rdata, rd);
    chk("wr_beats", wr_cnt, we ? nb : 0);
    chk("ready_busy", {31'h0, busy_rdy}, 32'h0);
    @(negedge clk);
    chk("ready_back", {31'h0, req_ready}, 32'h1);
    if (we) begin
      if (!flt)
        for (int j = 0; j < (1 << f3[1:0]); j++) begin
          ix = addr[7:0] + 8'(j);
          t  = wd >> (8 * j);
          shadow[ix] = t[7:0];
        end
      for (int j = 0; j < 4; j++) begin
        ix = addr[7:0] + 8'(j);
        chk("mem_byte", {24'h0, mem_arr[ix]}, {24'h0, shadow[ix]});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp", {31'h0, resp_valid}, 32'h0);
    chk("rst_wr", {31'h0, mem_wr_en}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10", last_rd, 32'hDEADBEEF);

    do_req(1'b1, 3'b100, 32'h20, 32'h12345678);
    chk("st_f3_100", {31'h0, last_flt}, 32'h1);

`ifdef LSU_MISALIGN_SPLIT_EN
    for (int i = 0; i < 4; i++) begin
      poke(8'(4 + i), 8'(8'h11 * (i + 1)));
      poke(8'(8 + i), 8'(8'h55 + 8'h11 * i));
    end
    do_req(1'b0, 3'b010, 32'h7, 32'h0);
    chk("lw_7", last_rd, 32'h77665544);
    poke(8'h3, 8'h80); poke(8'h4, 8'hFF);
    do_req(1'b0, 3'b001, 32'h3, 32'h0);
    chk("lh_3", last_rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h3, 32'h0);
    chk("lhu_3", last_rd, 32'h0000FF80);
    do_req(1'b1, 3'b001, 32'h3, 32'h0000ABCD);
    chk("sh_b3", {24'h0, mem_arr[3]}, 32'hCD);
    chk("sh_b4", {24'h0, mem_arr[4]}, 32'hAB);

    begin
      bit seen;
      for (int i = 1; i <= 4; i++) poke(8'(i), 8'(8'hA0 + i));
      chk("mid_ready", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1; req_wdata = 32'h11223344;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
      reset = 1'b0;
      chk("mid_no_resp", {31'h0, seen}, 32'h0);
      chk("mid_b1", {24'h0, mem_arr[1]}, 32'h44);
      chk("mid_b2", {24'h0, mem_arr[2]}, 32'h33);
      chk("mid_b3", {24'h0, mem_arr[3]}, 32'hA3);
      chk("mid_b4", {24'h0, mem_arr[4]}, 32'hA4);
      shadow[1] = 8'h44; shadow[2] = 8'h33;
      @(negedge clk);
      chk("mid_ready_back", {31'h0, req_ready}, 32'h1);
    end
`else
    do_req(1'b0, 3'b010, 32'h2, 32'h0);
    chk("lw_2_fault", {31'h0, last_flt}, 32'h1);
`endif

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else                           a = $urandom_range(0, 40);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
